uart_pkt_sched: RTL and testbench

- Packet scheduler in front of the byte-serial UART transmitter (wrreq/wdata/rdy interface, 10-bit 8N1 frames).
- Round-robin arbitrates two sample requesters (e.g. DAC readback and ADC capture channels).
- Each granted 16-bit sample is framed into a fixed 5-byte packet and fed to the UART one byte at a time.
- Sits between the sample sources and uart_tx, and is the only writer to uart_tx.

---
 rtl/uart_pkt_sched.sv | 147 ++++++++++++++
 tb/tb_uart_pkt_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_sched.sv
// uart_pkt_sched
//   Round-robin packet scheduler in front of a byte-serial UART transmitter.
//   Two sample channels request service; the granted 16-bit sample is framed
//   as HEADER, ID, data[15:8], data[7:0], CHK (XOR of the first four bytes)
//   and handed to the UART one byte at a time over a wrreq/wdata/rdy handshake.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   ch0_valid/data/ack       channel 0 request, sample, latch pulse
//   ch1_valid/data/ack       channel 1 request, sample, latch pulse
//   tx_rdy                   UART idle flag (low while a frame is on the wire)
//   tx_wrreq, tx_wdata       one-cycle write strobe and byte to the UART
//   busy                     high while a packet is being loaded or sent
//   pkt_cnt                  completed-packet counter (wraps)
module uart_pkt_sched #(
    parameter int          DW     = 16,
    parameter logic [7:0]  HEADER = 8'hA5,
    parameter logic [7:0]  ID0    = 8'h00,
    parameter logic [7:0]  ID1    = 8'h01
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ch0_valid,
    input  logic [DW-1:0] ch0_data,
    output logic          ch0_ack,
    input  logic          ch1_valid,
    input  logic [DW-1:0] ch1_data,
    output logic          ch1_ack,
    input  logic          tx_rdy,
    output logic          tx_wrreq,
    output logic [7:0]    tx_wdata,
    output logic          busy,
    output logic [15:0]   pkt_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ISSUE   = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t        state, state_nx;
    logic          grant;        // channel selected in IDLE, used in LOAD
    logic          last_grant;   // channel served by the previous packet
    logic [DW-1:0] shadow;       // sample of the packet in flight
    logic [2:0]    byte_idx;     // index of the byte currently on tx_wdata
    logic [7:0]    id_byte;
    logic [7:0]    chk_byte;
    logic [7:0]    next_byte;
    logic          any_valid;

    assign any_valid = ch0_valid | ch1_valid;
    assign id_byte   = grant ? ID1 : ID0;
    assign chk_byte  = HEADER ^ id_byte ^ shadow[15:8] ^ shadow[7:0];

    // Byte that follows the one currently indexed by byte_idx.
    always_comb begin
        next_byte = chk_byte;
        case (byte_idx)
            3'd0:    next_byte = id_byte;
            3'd1:    next_byte = shadow[15:8];
            3'd2:    next_byte = shadow[7:0];
            default: next_byte = chk_byte;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tx_wrreq = 1'b0;
        ch0_ack  = 1'b0;
        ch1_ack  = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_valid) state_nx = LOAD;
            end
            LOAD: begin
                ch0_ack  = ~grant;
                ch1_ack  = grant;
                state_nx = ISSUE;
            end
            ISSUE: begin
                // Never strobe while the UART is still shifting a frame.
                if (tx_rdy) begin
                    tx_wrreq = 1'b1;
                    state_nx = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_rdy) state_nx = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_rdy) state_nx = (byte_idx == 3'd4) ? IDLE : ISSUE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: tx_wdata only moves in LOAD or when leaving WAIT_HI, i.e.
    // only while tx_rdy=1, so the UART sees a stable byte for a whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            shadow     <= '0;
            byte_idx   <= 3'd0;
            tx_wdata   <= 8'h00;
            pkt_cnt    <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid)
                        grant <= (ch0_valid && ch1_valid) ? ~last_grant : ch1_valid;
                end
                LOAD: begin
                    shadow     <= grant ? ch1_data : ch0_data;
                    last_grant <= grant;
                    byte_idx   <= 3'd0;
                    tx_wdata   <= HEADER;
                end
                WAIT_HI: begin
                    if (tx_rdy) begin
                        if (byte_idx == 3'd4) begin
                            pkt_cnt <= pkt_cnt + 16'd1;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_wdata <= next_byte;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pkt_sched.sv
// Directed bench for uart_pkt_sched. A behavioural UART stand-in (16 clocks
// per bit, 10-bit frames) drives tx_rdy, captures every byte strobed by
// tx_wrreq, and flags any change of tx_wdata while a frame is in progress.
module tb_uart_pkt_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        ch0_valid, ch1_valid;
    logic [15:0] ch0_data, ch1_data;
    logic        ch0_ack, ch1_ack;
    logic        tx_rdy;
    logic        tx_wrreq;
    logic [7:0]  tx_wdata;
    logic        busy;
    logic [15:0] pkt_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_pkt_sched dut (
        .clk       (clk),
        .rst       (rst),
        .ch0_valid (ch0_valid),
        .ch0_data  (ch0_data),
        .ch0_ack   (ch0_ack),
        .ch1_valid (ch1_valid),
        .ch1_data  (ch1_data),
        .ch1_ack   (ch1_ack),
        .tx_rdy    (tx_rdy),
        .tx_wrreq  (tx_wrreq),
        .tx_wdata  (tx_wdata),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt)
    );

    // UART stand-in
    localparam int FRAME = 160;
    logic [7:0] byteq[$];
    logic [7:0] cap;
    int         bitcnt;
    int         wr_total  = 0;
    int         stab_err  = 0;
    int         wr_viol   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_rdy <= 1'b1;
            bitcnt <= 0;
        end else if (tx_rdy) begin
            if (tx_wrreq) begin
                cap      <= tx_wdata;
                byteq.push_back(tx_wdata);
                wr_total <= wr_total + 1;
                tx_rdy   <= 1'b0;
                bitcnt   <= FRAME - 1;
            end
        end else begin
            if (tx_wrreq)      wr_viol  <= wr_viol + 1;
            if (tx_wdata != cap) stab_err <= stab_err + 1;
            if (bitcnt == 0) tx_rdy <= 1'b1;
            else             bitcnt <= bitcnt - 1;
        end
    end

    // Ack monitor: grant order and per-channel counts
    int   ack0_n = 0;
    int   ack1_n = 0;
    logic grants[$];
    always @(posedge clk) begin
        if (ch0_ack) begin ack0_n <= ack0_n + 1; grants.push_back(1'b0); end
        if (ch1_ack) begin ack1_n <= ack1_n + 1; grants.push_back(1'b1); end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    int rd = 0;  // next unread entry of byteq

    task automatic wait_bytes(input string tag, input int n, input int bound);
        int k = 0;
        while (byteq.size() < rd + n && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_bytes_arrived"}, byteq.size() >= rd + n, 1);
    endtask

    task automatic chk_pkt(input string tag, input logic [7:0] id, input logic [15:0] d);
        logic [7:0] exp [5];
        exp[0] = 8'hA5;
        exp[1] = id;
        exp[2] = d[15:8];
        exp[3] = d[7:0];
        exp[4] = 8'hA5 ^ id ^ d[15:8] ^ d[7:0];
        wait_bytes(tag, 5, 3000);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_b%0d", tag, i),
                (rd + i < byteq.size()) ? byteq[rd + i] : 8'hxx, exp[i]);
        rd += 5;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    // Raise valid on one channel, wait for its ack, drop valid.
    task automatic send(input string tag, input bit ch, input logic [15:0] d);
        int k = 0;
        @(negedge clk);
        if (ch) begin ch1_valid = 1'b1; ch1_data = d; end
        else    begin ch0_valid = 1'b1; ch0_data = d; end
        @(negedge clk);
        while (!(ch ? ch1_ack : ch0_ack) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ack_seen"}, ch ? ch1_ack : ch0_ack, 1);
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
    endtask

    initial begin
        int a0, a1, p0, wr_base, k;
        rst = 1'b1;
        ch0_valid = 1'b0; ch1_valid = 1'b0;
        ch0_data = 16'h0; ch1_data = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_wrreq", tx_wrreq, 0);
        chk("rst_wdata", tx_wdata, 8'h00);
        chk("rst_busy",  busy, 0);
        chk("rst_cnt",   pkt_cnt, 0);
        chk("rst_acks",  {ch0_ack, ch1_ack}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // 1: ch0 0x1234, ack one cycle later, wrreq one cycle after ack
        ch0_valid = 1'b1; ch0_data = 16'h1234;
        @(negedge clk);
        chk("t1_ack_latency", ch0_ack, 1);
        ch0_valid = 1'b0;
        @(negedge clk);
        chk("t1_ack_pulse", ch0_ack, 0);
        chk("t1_wrreq_latency", tx_wrreq, 1);
        chk_pkt("t1", 8'h00, 16'h1234);
        wait_idle("t1");
        chk("t1_cnt", pkt_cnt, 1);
        chk("t1_ack0_n", ack0_n, 1);

        // 2: ch1 only
        a0 = ack0_n;
        send("t2", 1'b1, 16'hABCD);
        chk_pkt("t2", 8'h01, 16'hABCD);
        wait_idle("t2");
        chk("t2_no_ack0", ack0_n, a0);
        chk("t2_cnt", pkt_cnt, 2);

        // 3: both held continuously for four grants
        a0 = ack0_n; a1 = ack1_n; p0 = grants.size();
        @(negedge clk);
        ch0_valid = 1'b1; ch0_data = 16'h1111;
        ch1_valid = 1'b1; ch1_data = 16'h2222;
        k = 0;
        while (grants.size() < p0 + 4 && k < 6000) begin
            @(negedge clk);
            k++;
        end
        ch0_valid = 1'b0; ch1_valid = 1'b0;
        chk("t3_grants_n", grants.size(), p0 + 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_grant%0d", i),
                (p0 + i < grants.size()) ? grants[p0 + i] : 1'bx, i[0]);
        chk_pkt("t3p0", 8'h00, 16'h1111);
        chk_pkt("t3p1", 8'h01, 16'h2222);
        chk_pkt("t3p2", 8'h00, 16'h1111);
        chk_pkt("t3p3", 8'h01, 16'h2222);
        wait_idle("t3");
        chk("t3_ack0_n", ack0_n, a0 + 2);
        chk("t3_ack1_n", ack1_n, a1 + 2);
        chk("t3_cnt", pkt_cnt, 6);

        // 4: source data changes right after ack; shadow keeps the old sample
        send("t4", 1'b0, 16'h1234);
        @(negedge clk);
        ch0_data = 16'hFFFF;
        chk_pkt("t4", 8'h00, 16'h1234);
        wait_idle("t4");
        chk("t4_cnt", pkt_cnt, 7);

        // 5: reset during the third byte
        wr_base = wr_total;
        send("t5", 1'b1, 16'h5678);
        k = 0;
        while (wr_total < wr_base + 3 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("t5_third_byte", wr_total, wr_base + 3);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_wrreq", tx_wrreq, 0);
        chk("t5_rst_busy",  busy, 0);
        chk("t5_rst_cnt",   pkt_cnt, 0);
        chk("t5_rst_wdata", tx_wdata, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        rd = byteq.size();
        send("t5b", 1'b1, 16'h9A0B);
        chk_pkt("t5b", 8'h01, 16'h9A0B);
        wait_idle("t5b");
        chk("t5_cnt", pkt_cnt, 1);

        // 6: counter wrap
        @(negedge clk);
        force dut.pkt_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_cnt;
        chk("t6_preload", pkt_cnt, 16'hFFFF);
        send("t6", 1'b0, 16'h00FF);
        chk_pkt("t6", 8'h00, 16'h00FF);
        wait_idle("t6");
        chk("t6_wrap", pkt_cnt, 16'h0000);

        // 7 full packets + 3 partial bytes + 2 packets after reset
        repeat (2) @(negedge clk);
        chk("wrreq_total", wr_total, 48);
        chk("wrreq_while_rdy_low", wr_viol, 0);
        chk("wdata_stable_in_frame", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
